// File: rtl/press_window_controller_pkg.sv
// Shared state encoding, widths and helpers for the press-window controller.
package press_window_controller_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    WINDOW = 2'd2,
    COMMIT = 2'd3
  } state_t;

  localparam int         MODE_W    = 2;
  localparam int         COUNT_W   = 32;
  localparam logic [1:0] PRESS_MAX = 2'd3;

  function automatic logic [1:0] sat_inc(input logic [1:0] v);
    return (v == PRESS_MAX) ? v : v + 2'd1;
  endfunction

endpackage

// File: rtl/press_window_controller_sec_tick_gen.sv
// Free-running 1 s prescaler: one-cycle tick every CLK_HZ enabled cycles.
module sec_tick_gen #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int            PW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] LAST = PW'(CLK_HZ - 1);

  logic [PW-1:0] pre;

  assign tick = en & ~clr & (pre == LAST);

  // clr wins over en so the window always starts from a clean phase
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        pre <= '0;
    else if (clr)     pre <= '0;
    else if (en)      pre <= (pre == LAST) ? '0 : pre + 1'b1;
  end

endmodule

// File: rtl/press_window_controller.sv
// Press-counting window sequencer: arms a window, counts button edges, commits mode.
module press_window_controller
  import press_window_controller_pkg::*;
#(
  parameter int                 CLK_HZ   = 100_000_000,
  parameter logic [COUNT_W-1:0] WINDOW_S = 32'd3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pushbutton,
  input  logic               enable,
  output logic               new_state,
  output logic [COUNT_W-1:0] count,
  output logic [1:0]         press_count,
  output logic [MODE_W-1:0]  mode,
  output logic               commit,
  output logic               busy
);

  state_t state;
  logic   btn_q;
  logic   tick;
  logic   pre_clr;
  logic   pre_en;
  logic   press;

  assign pre_en  = (state == WINDOW);
  assign pre_clr = (state != WINDOW);
  assign press   = pushbutton & ~btn_q;

  sec_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (pre_clr),
    .en    (pre_en),
    .tick  (tick)
  );

  assign new_state = (state == ARM);
  assign commit    = (state == COMMIT);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      btn_q       <= 1'b0;
      count       <= '0;
      press_count <= '0;
      mode        <= '0;
    end else begin
      // loaded in ARM too, so a button already held at window start is not a press
      btn_q <= pushbutton;
      case (state)
        IDLE: if (enable) state <= ARM;
        ARM: begin
          count       <= WINDOW_S;
          press_count <= '0;
          state       <= WINDOW;
        end
        WINDOW: begin
          if (!enable) begin
            state       <= IDLE;
            count       <= '0;
            press_count <= '0;
          end else begin
            if (press) press_count <= sat_inc(press_count);
            if (tick) begin
              if (count == 32'd1) begin
                count <= '0;
                state <= COMMIT;
              end else if (count != '0) begin
                count <= count - 32'd1;
              end
            end
          end
        end
        COMMIT: begin
          mode  <= mode + press_count;
          state <= enable ? ARM : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_press_window_controller.sv
// Bench: table + directed corner cases + random stimulus against a phase-based model.
module tb_press_window_controller;

  localparam int C = 4;
  localparam int W = 3;
  localparam int N = W * C;

  typedef logic [38:0] obs_t;
  typedef struct {
    logic en;
    logic btn;
    obs_t exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, en, btn;
  logic        new_state, commit, busy;
  logic [31:0] count;
  logic [1:0]  press_count, mode;

  int checks = 0;
  int errors = 0;

  press_window_controller #(.CLK_HZ(C), .WINDOW_S(32'd3)) dut (
    .clk         (clk),
    .reset       (rst),
    .pushbutton  (btn),
    .enable      (en),
    .new_state   (new_state),
    .count       (count),
    .press_count (press_count),
    .mode        (mode),
    .commit      (commit),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Reference: position within the window as a phase index (0 = arm, 1..N = window, N+1 = commit)
  bit m_act;
  int m_phase, m_press, m_mode;
  bit m_prev;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act <= 0; m_phase <= 0; m_press <= 0; m_mode <= 0; m_prev <= 0;
    end else begin
      m_prev <= btn;
      if (!m_act) begin
        if (en) begin m_act <= 1; m_phase <= 0; end
      end else if (m_phase == 0) begin
        m_phase <= 1; m_press <= 0;
      end else if (m_phase <= N) begin
        if (!en) begin
          m_act <= 0; m_press <= 0;
        end else begin
          if (btn && !m_prev && m_press < 3) m_press <= m_press + 1;
          m_phase <= m_phase + 1;
        end
      end else begin
        m_mode <= (m_mode + m_press) % 4;
        if (en) m_phase <= 0;
        else    m_act <= 0;
      end
    end
  end

  function automatic obs_t model_obs();
    int cnt;
    cnt = (m_act && m_phase >= 1 && m_phase <= N) ? W - (m_phase - 1) / C : 0;
    return {m_act && m_phase == 0, 32'(cnt), 2'(m_press), 2'(m_mode),
            m_act && m_phase == N + 1, m_act};
  endfunction

  function automatic obs_t dut_obs();
    return {new_state, count, press_count, mode, commit, busy};
  endfunction

  function automatic obs_t mk(logic ns, int cnt, int pc, int md, logic cm, logic bz);
    return {ns, 32'(cnt), 2'(pc), 2'(md), cm, bz};
  endfunction

  always @(negedge clk) begin
    checks++;
    if (dut_obs() !== model_obs()) begin
      errors++;
      $display("FAIL model t=%0t got=%h expected=%h", $time, dut_obs(), model_obs());
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic wait_commit(input string nm, input int budget);
    int i = 0;
    while (commit !== 1'b1 && i < budget) begin step(); i++; end
    checks++;
    if (commit !== 1'b1) begin
      errors++;
      $display("FAIL %s commit timeout got=%b expected=1", nm, commit);
    end
  endtask

  vec_t tbl[15];

  initial begin
    #500000;
    $display("FAIL watchdog expired got=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; en = 0; btn = 0;
    #12;
    chk("reset", dut_obs(), '0);
    step();
    rst = 0;

    tbl[0]  = '{1'b1, 1'b0, mk(1, 0, 0, 0, 0, 1)};
    tbl[1]  = '{1'b1, 1'b0, mk(0, 3, 0, 0, 0, 1)};
    tbl[2]  = '{1'b1, 1'b0, mk(0, 3, 0, 0, 0, 1)};
    tbl[3]  = '{1'b1, 1'b0, mk(0, 3, 0, 0, 0, 1)};
    tbl[4]  = '{1'b1, 1'b0, mk(0, 3, 0, 0, 0, 1)};
    tbl[5]  = '{1'b1, 1'b0, mk(0, 2, 0, 0, 0, 1)};
    tbl[6]  = '{1'b1, 1'b0, mk(0, 2, 0, 0, 0, 1)};
    tbl[7]  = '{1'b1, 1'b0, mk(0, 2, 0, 0, 0, 1)};
    tbl[8]  = '{1'b1, 1'b0, mk(0, 2, 0, 0, 0, 1)};
    tbl[9]  = '{1'b1, 1'b0, mk(0, 1, 0, 0, 0, 1)};
    tbl[10] = '{1'b1, 1'b0, mk(0, 1, 0, 0, 0, 1)};
    tbl[11] = '{1'b1, 1'b0, mk(0, 1, 0, 0, 0, 1)};
    tbl[12] = '{1'b1, 1'b0, mk(0, 1, 0, 0, 0, 1)};
    tbl[13] = '{1'b1, 1'b0, mk(0, 0, 0, 0, 1, 1)};
    tbl[14] = '{1'b1, 1'b0, mk(1, 0, 0, 0, 0, 1)};

    for (int i = 0; i < 15; i++) begin
      en = tbl[i].en; btn = tbl[i].btn;
      step();
      chk($sformatf("t1_row%0d", i), dut_obs(), tbl[i].exp);
    end

    // two 2-cycle presses
    btn = 0; step(); chk_i("t2_count", int'(count), 3);
    btn = 1; step(); step(); btn = 0; step(); step(); btn = 1; step(); step(); btn = 0;
    wait_commit("t2", 20);
    chk_i("t2_press", int'(press_count), 2);
    chk_i("t2_mode_pre", int'(mode), 0);
    step();
    chk_i("t2_mode", int'(mode), 2);
    chk_i("t2_rearm", int'(new_state), 1);

    // five presses saturate at 3, mode wraps 2 -> 1
    btn = 0; step();
    for (int k = 0; k < 5; k++) begin btn = 1; step(); btn = 0; step(); end
    wait_commit("t3", 20);
    chk_i("t3_press", int'(press_count), 3);
    btn = 1; step();
    chk_i("t3_mode", int'(mode), 1);

    // button held across the whole window
    step();
    wait_commit("t4a", 20);
    chk_i("t4a_press", int'(press_count), 0);
    btn = 0; step();
    chk_i("t4a_mode", int'(mode), 1);

    // single edge on the final tick
    step();
    repeat (11) step();
    chk_i("t4b_last_count", int'(count), 1);
    btn = 1; step();
    chk_i("t4b_commit", int'(commit), 1);
    chk_i("t4b_press", int'(press_count), 1);
    btn = 0; step();
    chk_i("t4b_mode", int'(mode), 2);

    // disable mid-window
    step(); repeat (4) step();
    chk_i("t5_count", int'(count), 2);
    en = 0; step();
    chk("t5_idle", dut_obs(), mk(0, 0, 0, 2, 0, 0));
    step(); step();
    chk("t5_stay", dut_obs(), mk(0, 0, 0, 2, 0, 0));
    en = 1; step();
    chk_i("t5_rearm", int'(new_state), 1);
    step(); step(); step();

    // async reset between edges
    @(posedge clk); #2 rst = 1; #1;
    chk("t6_async", dut_obs(), '0);
    step();
    rst = 0; en = 1;
    step();
    chk("t6_arm", dut_obs(), mk(1, 0, 0, 0, 0, 1));
    step();
    chk_i("t6_count", int'(count), 3);

    for (int i = 0; i < 3000; i++) begin
      #1;
      rst = ($urandom_range(0, 599) == 0);
      en  = ($urandom_range(0, 99) < 96);
      if ($urandom_range(0, 9) < 3) btn = ~btn;
      step();
    end
    #1 rst = 0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
